// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver.
//   rx_state_t          - receiver FSM state encoding
//   DEFAULT_CLK_PER_BIT - 9600 baud at a 50 MHz clock
//   DATA_W              - width of one received character
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 5208;
  localparam int DATA_W              = 8;

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst    - clock, asynchronous active-low reset
//   push, din   - write request and data (accepted when not full, or when
//                 a pop happens in the same cycle)
//   pop         - read request (ignored while empty)
//   dout        - head entry; reads as zero while empty
//   count       - occupancy, 0..DEPTH
//   full, empty - status flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a write when it is being read.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; only pointers and occupancy define contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver feeding a show-ahead receive FIFO.
//   clk        - system clock (rising edge)
//   rst        - asynchronous active-low reset
//   rx_in      - asynchronous serial line, idle high
//   rx_data    - byte at FIFO head
//   rx_valid   - FIFO non-empty
//   rx_ready   - consumer accept; pop on rx_valid && rx_ready
//   fifo_count - FIFO occupancy
//   frame_err  - one-cycle pulse when the stop bit samples low
//   overrun    - one-cycle pulse when a good byte is dropped (FIFO full)
//   busy       - receiver not idle
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_in,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BIT - 1);
  localparam int          BW      = $clog2(DATA_W);

  logic              sync1_reg;
  logic              sync2_reg;
  logic              prev_reg;
  logic [1:0]        fill_reg;
  logic              armed_reg;
  rx_state_t         state_reg, state_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [BW-1:0]     bit_reg, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              push_en;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;
  assign busy     = (state_reg != ST_IDLE);

  // Synchronizer and arming. fill_reg marks when sync2_reg holds a real
  // line sample rather than its reset value, so a line held low through
  // reset never looks like a high-to-low start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      fill_reg  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sync1_reg <= rx_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
      armed_reg <= armed_reg | (fill_reg[1] & sync2_reg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 16'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    push_en    = 1'b0;
    frame_err  = 1'b0;
    overrun    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (armed_reg && prev_reg && !sync2_reg) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        // Re-check the start bit at its midpoint; high means a glitch.
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2_reg ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[DATA_W-1:1]};
          bit_next   = bit_reg + BW'(1);
          if (bit_reg == BW'(DATA_W - 1)) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next = '0;
          if (sync2_reg) begin
            // A same-cycle pop makes room even when full.
            if (fifo_full && !pop) overrun = 1'b1;
            else                   push_en = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_next = '0;
        if (sync2_reg) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_en),
    .pop   (pop),
    .din   (shift_reg),
    .dout  (rx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: queue-based model of the receive FIFO with a
// per-cycle compare process, plus literal checks on the scenarios.
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  // Edges from the line falling to the stop-bit sample: two synchronizer
  // flops plus one edge-detect cycle, half a bit to mid start, then eight
  // data bits and the stop bit one full bit apart.
  localparam int LAT   = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;

  typedef struct packed {
    int         at_edge;
    logic [7:0] b;
    logic       good;
  } ev_t;

  logic [7:0] q[$];
  ev_t        sched[$];

  uart_rx_buffered #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: FIFO contents as a queue, received frames as scheduled events.
  always @(posedge clk) begin
    logic do_pop, was_full;
    cyc++;
    if (!rst) begin
      q.delete();
      sched.delete();
    end else begin
      do_pop   = (q.size() != 0) && rx_ready;
      was_full = (q.size() == DEPTH);
      if (do_pop) void'(q.pop_front());
      if (sched.size() != 0 && sched[0].at_edge == cyc) begin
        if (sched[0].good && (!was_full || do_pop)) q.push_back(sched[0].b);
        void'(sched.pop_front());
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    logic exp_fe, exp_ov;
    if (frame_err) fe_seen++;
    if (overrun)   ov_seen++;
    if (!rst) begin
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);
    end else begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (sched.size() != 0 && sched[0].at_edge == cyc + 1) begin
        exp_fe = !sched[0].good;
        exp_ov = sched[0].good && (q.size() == DEPTH) && !rx_ready;
      end
      check("valid", rx_valid, (q.size() != 0));
      check("count", fifo_count, q.size());
      if (q.size() != 0) check("data", rx_data, q[0]);
      check("frame_err", frame_err, exp_fe);
      check("overrun", overrun, exp_ov);
    end
  end

  // Call at #1 after a rising edge with the line idle high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    e.at_edge = cyc + LAT;
    e.b       = b;
    e.good    = stop_bit;
    sched.push_back(e);
    rx_in = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_in = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    if (stop_bit) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst = 1'b1;
    idle(10);

    // Pop while empty must be harmless.
    rx_ready = 1'b1;
    idle(3);
    rx_ready = 1'b0;
    check("empty_pop_count", fifo_count, 0);

    // Single frame 0xA5, consumer not ready.
    send_frame(8'hA5, 1'b1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_count", fifo_count, 1);
    check("a5_busy", busy, 0);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    check("a5_drained", fifo_count, 0);

    // Short low glitch rejected at the start-bit midpoint.
    rx_in = 1'b0;
    idle(5);
    rx_in = 1'b1;
    idle(20);
    check("glitch_busy", busy, 0);
    check("glitch_count", fifo_count, 0);
    check("glitch_flags", fe_seen + ov_seen, 0);

    // Framing error: stop bit low, line held low afterwards.
    send_frame(8'h3C, 1'b0);
    idle(30);
    check("break_busy", busy, 1);
    check("fe_pulses", fe_seen, 1);
    check("fe_count", fifo_count, 0);
    rx_in = 1'b1;
    idle(6);
    check("break_exit", busy, 0);

    // Nine frames into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    check("ovr_count", fifo_count, 8);
    check("ovr_pulses", ov_seen, 1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("ovr_order", rx_data, i);
      @(posedge clk);
      #1;
    end
    rx_ready = 1'b0;
    check("ovr_empty", fifo_count, 0);

    // Full FIFO, pop in the push cycle of 0x55.
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1);
    check("full_count", fifo_count, 8);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check("pp_count", fifo_count, 8);
    check("pp_no_ovr", ov_seen, 1);
    check("pp_head", rx_data, 8'h12);
    rx_ready = 1'b1;
    idle(7);
    rx_ready = 1'b0;
    check("pp_last", rx_data, 8'h55);
    check("pp_last_count", fifo_count, 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;

    // Reset in the middle of bit 4, line low through release.
    rx_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = i[0];
      idle(CPB);
    end
    rx_in = 1'b1;
    idle(CPB / 2);
    rst = 1'b0;
    rx_in = 1'b0;
    idle(5);
    rst = 1'b1;
    idle(40);
    check("rst_low_busy", busy, 0);
    check("rst_low_valid", rx_valid, 0);
    rx_in = 1'b1;
    idle(20);
    send_frame(8'h7E, 1'b1);
    check("post_rst_data", rx_data, 8'h7E);
    check("post_rst_count", fifo_count, 1);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
